// File: rtl/ase_umsg_ctrl.sv
// ase_umsg_ctrl: per-slot UMsg hint/data delay engine with round-robin arbitration into one registered output stage.
// Define ASE_UMSG_COALESCE_EN to let commands to waiting slots overwrite their payload.
module ase_umsg_ctrl #(
  parameter int NUM_UMSG    = 8,
  parameter int TIMER_WIDTH = 8,
  parameter int HINT_DELAY  = 16,
  parameter int DATA_DELAY  = 32,
  parameter int DATA_WIDTH  = 512
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [NUM_UMSG-1:0]                               umsg_hint_en,
  input  logic                                              cmd_valid,
  input  logic [(NUM_UMSG > 1 ? $clog2(NUM_UMSG) : 1)-1:0]  cmd_id,
  input  logic [DATA_WIDTH-1:0]                             cmd_data,
  output logic                                              cmd_ready,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [27:0]                                       out_hdr,
  output logic [DATA_WIDTH-1:0]                             out_data,
  output logic [NUM_UMSG-1:0]                               slot_busy
);
  localparam int IDW = NUM_UMSG > 1 ? $clog2(NUM_UMSG) : 1;
`ifdef ASE_UMSG_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, HINT_WAIT, SEND_HINT, DATA_WAIT, SEND_DATA} state_t;
  state_t                 state_q [NUM_UMSG];
  state_t                 state_d [NUM_UMSG];
  logic [TIMER_WIDTH-1:0] timer_q [NUM_UMSG];
  logic [TIMER_WIDTH-1:0] timer_d [NUM_UMSG];
  logic [DATA_WIDTH-1:0]  data_q  [NUM_UMSG];
  logic [DATA_WIDTH-1:0]  data_d  [NUM_UMSG];
  logic [IDW-1:0]         ptr_q, ptr_d, win, idx;
  logic [NUM_UMSG-1:0]    req;
  logic                   found, load, win_hint, accept;
  logic                   out_valid_q, out_valid_d;
  logic [27:0]            out_hdr_q, out_hdr_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  int                     pos;
  always_comb begin
    req = '0;
    slot_busy = '0;
    cmd_ready = 1'b0;
    for (int i = 0; i < NUM_UMSG; i++) begin
      req[i] = state_q[i] == SEND_HINT || state_q[i] == SEND_DATA;
      slot_busy[i] = state_q[i] != IDLE;
      if (cmd_id == IDW'(i))
        cmd_ready = state_q[i] == IDLE ||
                    (COALESCE && (state_q[i] == HINT_WAIT || state_q[i] == DATA_WAIT));
    end
    accept = cmd_valid && cmd_ready;
    found = 1'b0;
    win = '0;
    idx = '0;
    pos = 0;
    // Search begins at the RR pointer and wraps; the first requester wins.
    for (int k = 0; k < NUM_UMSG; k++) begin
      pos = int'(ptr_q) + k;
      pos = pos >= NUM_UMSG ? pos - NUM_UMSG : pos;
      idx = IDW'(pos);
      if (!found && req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    load = found && (!out_valid_q || out_ready);
    win_hint = state_q[win] == SEND_HINT;
  end
  always_comb begin
    for (int i = 0; i < NUM_UMSG; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      data_d[i] = data_q[i];
      case (state_q[i])
        HINT_WAIT: begin
          timer_d[i] = timer_q[i] != '0 ? timer_q[i] - TIMER_WIDTH'(1) : timer_q[i];
          state_d[i] = timer_q[i] == '0 ? SEND_HINT : HINT_WAIT;
        end
        DATA_WAIT: begin
          timer_d[i] = timer_q[i] != '0 ? timer_q[i] - TIMER_WIDTH'(1) : timer_q[i];
          state_d[i] = timer_q[i] == '0 ? SEND_DATA : DATA_WAIT;
        end
        SEND_HINT: if (load && win == IDW'(i)) begin
          state_d[i] = DATA_WAIT;
          timer_d[i] = TIMER_WIDTH'(DATA_DELAY);
        end
        SEND_DATA: if (load && win == IDW'(i)) state_d[i] = IDLE;
        default: ;
      endcase
      // A coalescing accept only refreshes the payload; state and timer run on.
      if (accept && cmd_id == IDW'(i)) begin
        data_d[i] = cmd_data;
        if (state_q[i] == IDLE) begin
          state_d[i] = umsg_hint_en[i] ? HINT_WAIT : DATA_WAIT;
          timer_d[i] = umsg_hint_en[i] ? TIMER_WIDTH'(HINT_DELAY) : TIMER_WIDTH'(DATA_DELAY);
        end
      end
    end
    ptr_d = load ? (int'(win) == NUM_UMSG - 1 ? '0 : win + 1'b1) : ptr_q;
    out_valid_d = load ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
    out_hdr_d = load ? {8'h00, 4'h6, win_hint, 9'h000, 6'(win)} : out_hdr_q;
    out_data_d = load ? (win_hint ? '0 : data_q[win]) : out_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
        data_q[i] <= '0;
      end
      ptr_q <= '0;
      out_valid_q <= 1'b0;
      out_hdr_q <= '0;
      out_data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_UMSG; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        data_q[i] <= data_d[i];
      end
      ptr_q <= ptr_d;
      out_valid_q <= out_valid_d;
      out_hdr_q <= out_hdr_d;
      out_data_q <= out_data_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_hdr = out_hdr_q;
  assign out_data = out_data_q;
endmodule
